// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready and shifts them out one bit per clock.
// A one-entry hold register lets consecutive words stream with no idle bit between them.
module seq_bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_full;
  logic             r_ser_out;
  logic             r_bit_valid;
  logic             r_frame_start;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_hold_data_nxt;
  logic             w_hold_full_nxt;
  logic             w_ser_nxt;
  logic             w_bv_nxt;
  logic             w_fs_nxt;
  logic             w_busy_nxt;
  logic             w_accept;

  // Bit at serial position idx of a word, honouring the shift order.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word, input logic [CW-1:0] idx);
    logic [CW-1:0] pos;
    if (MSB_FIRST) begin
      pos = CNT_LAST - idx;
    end else begin
      pos = idx;
    end
    return word[pos];
  endfunction

  assign w_accept    = load_valid & ~r_hold_full;
  assign load_ready  = ~r_hold_full;
  assign ser_out     = r_ser_out;
  assign bit_valid   = r_bit_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

  // Next-state and next-output decode; r_cnt is the index of the bit currently on ser_out.
  always_comb begin
    w_state_nxt     = r_state;
    w_sh_nxt        = r_sh;
    w_cnt_nxt       = r_cnt;
    w_hold_data_nxt = r_hold_data;
    w_hold_full_nxt = r_hold_full;
    w_ser_nxt       = IDLE_BIT;
    w_bv_nxt        = 1'b0;
    w_fs_nxt        = 1'b0;
    w_busy_nxt      = 1'b0;

    if (clear) begin
      w_state_nxt     = ST_IDLE;
      w_hold_full_nxt = 1'b0;
      w_cnt_nxt       = {CW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_sh_nxt    = load_data;
            w_cnt_nxt   = {CW{1'b0}};
            w_ser_nxt   = pick_bit(load_data, {CW{1'b0}});
            w_bv_nxt    = 1'b1;
            w_fs_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            // Word boundary: reload from hold first, else take a same-edge accept, else go idle.
            if (r_hold_full) begin
              w_sh_nxt        = r_hold_data;
              w_hold_full_nxt = 1'b0;
              w_cnt_nxt       = {CW{1'b0}};
              w_ser_nxt       = pick_bit(r_hold_data, {CW{1'b0}});
              w_bv_nxt        = 1'b1;
              w_fs_nxt        = 1'b1;
              w_busy_nxt      = 1'b1;
            end else if (w_accept) begin
              w_sh_nxt   = load_data;
              w_cnt_nxt  = {CW{1'b0}};
              w_ser_nxt  = pick_bit(load_data, {CW{1'b0}});
              w_bv_nxt   = 1'b1;
              w_fs_nxt   = 1'b1;
              w_busy_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = {CW{1'b0}};
            end
          end else begin
            w_cnt_nxt  = r_cnt + CW'(1);
            w_ser_nxt  = pick_bit(r_sh, r_cnt + CW'(1));
            w_bv_nxt   = 1'b1;
            w_busy_nxt = 1'b1;
            if (w_accept) begin
              w_hold_data_nxt = load_data;
              w_hold_full_nxt = 1'b1;
            end else begin
              w_hold_full_nxt = r_hold_full;
            end
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_hold_full_nxt = 1'b0;
          w_cnt_nxt       = {CW{1'b0}};
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_sh          <= {WIDTH{1'b0}};
      r_cnt         <= {CW{1'b0}};
      r_hold_data   <= {WIDTH{1'b0}};
      r_hold_full   <= 1'b0;
      r_ser_out     <= IDLE_BIT;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sh          <= w_sh_nxt;
      r_cnt         <= w_cnt_nxt;
      r_hold_data   <= w_hold_data_nxt;
      r_hold_full   <= w_hold_full_nxt;
      r_ser_out     <= w_ser_nxt;
      r_bit_valid   <= w_bv_nxt;
      r_frame_start <= w_fs_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus,
// expected bit streams are hand-written word constants.
module tb_seq_bit_serializer;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [7:0] load_data;
  logic       load_valid;

  logic rdy_m, ser_m, bv_m, fs_m, busy_m;
  logic rdy_l, ser_l, bv_l, fs_l, busy_l;

  int n_pass;
  int n_total;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .clear(clear),
    .load_data(load_data), .load_valid(load_valid), .load_ready(rdy_m),
    .ser_out(ser_m), .bit_valid(bv_m), .frame_start(fs_m), .busy(busy_m)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .clear(clear),
    .load_data(load_data), .load_valid(load_valid), .load_ready(rdy_l),
    .ser_out(ser_l), .bit_valid(bv_l), .frame_start(fs_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ser"},  {31'd0, ser_m},  32'd0);
    chk({tag, "_bv"},   {31'd0, bv_m},   32'd0);
    chk({tag, "_fs"},   {31'd0, fs_m},   32'd0);
    chk({tag, "_busy"}, {31'd0, busy_m}, 32'd0);
    chk({tag, "_rdy"},  {31'd0, rdy_m},  32'd1);
  endtask

  // Checks the 8 bits of word w, one per cycle, starting on the cycle of its first bit.
  task automatic check_word(input string tag, input logic [7:0] w, input bit use_lsb);
    for (int i = 0; i < 8; i++) begin
      if (use_lsb) begin
        chk({tag, "_ser"}, {31'd0, ser_l}, {31'd0, w[i]});
        chk({tag, "_bv"},  {31'd0, bv_l},  32'd1);
        chk({tag, "_fs"},  {31'd0, fs_l},  (i == 0) ? 32'd1 : 32'd0);
      end else begin
        chk({tag, "_ser"}, {31'd0, ser_m}, {31'd0, w[7-i]});
        chk({tag, "_bv"},  {31'd0, bv_m},  32'd1);
        chk({tag, "_fs"},  {31'd0, fs_m},  (i == 0) ? 32'd1 : 32'd0);
      end
      if (i < 7) tick();
    end
  endtask

  initial begin
    logic [15:0] stream;
    n_pass     = 0;
    n_total    = 0;
    reset      = 1'b0;
    clear      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;

    // Reset values, before any clock edge
    #3;
    chk_idle("rst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_idle("post_rst");

    // 1: single word D6, MSB first
    load_data  = 8'hD6;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    load_data  = 8'h5A;
    check_word("t1", 8'hD6, 1'b0);
    tick();
    chk_idle("t1_end");

    // 2: back-to-back D6 then 0D through the hold register
    stream     = 16'hD60D;
    load_data  = 8'hD6;
    load_valid = 1'b1;
    tick();
    load_data  = 8'h0D;
    for (int i = 0; i < 16; i++) begin
      chk("t2_ser",  {31'd0, ser_m},  {31'd0, stream[15-i]});
      chk("t2_bv",   {31'd0, bv_m},   32'd1);
      chk("t2_fs",   {31'd0, fs_m},   (i == 0 || i == 8) ? 32'd1 : 32'd0);
      chk("t2_rdy",  {31'd0, rdy_m},  (i == 0 || i >= 8) ? 32'd1 : 32'd0);
      chk("t2_busy", {31'd0, busy_m}, 32'd1);
      if (i < 15) tick();
      if (i == 0) load_valid = 1'b0;
    end
    tick();
    chk_idle("t2_end");

    // 3: accept FF exactly on the last bit with the hold empty
    load_data  = 8'hD6;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check_word("t3a", 8'hD6, 1'b0);
    chk("t3_rdy_last", {31'd0, rdy_m}, 32'd1);
    load_data  = 8'hFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check_word("t3b", 8'hFF, 1'b0);
    tick();
    chk_idle("t3_end");

    // 4: LSB-first instance, word 0B
    load_data  = 8'h0B;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check_word("t4", 8'h0B, 1'b1);
    tick();
    chk("t4_idle_bv", {31'd0, bv_l}, 32'd0);
    chk("t4_idle_ser", {31'd0, ser_l}, 32'd0);

    // 5: clear at bit 3 of D6 while AA sits in the hold
    load_data  = 8'hD6;
    load_valid = 1'b1;
    tick();
    load_data  = 8'hAA;
    tick();
    load_valid = 1'b0;
    chk("t5_rdy_held", {31'd0, rdy_m}, 32'd0);
    tick();
    tick();
    chk("t5_bit3", {31'd0, ser_m}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_idle("t5_clr");
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_no_aa", {31'd0, bv_m}, 32'd0);
    end
    // word presented during clear with ready high is dropped
    load_data  = 8'hFF;
    load_valid = 1'b1;
    clear      = 1'b1;
    tick();
    clear      = 1'b0;
    load_valid = 1'b0;
    chk_idle("t5_drop");
    tick();
    chk("t5_drop2_bv", {31'd0, bv_m}, 32'd0);

    // 6: async reset mid-word, then a clean word
    load_data  = 8'hD6;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk("t6_pre_bv", {31'd0, bv_m}, 32'd1);
    reset = 1'b0;
    #1;
    chk_idle("t6_async");
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_idle("t6_rel");
    load_data  = 8'h0D;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check_word("t6", 8'h0D, 1'b0);
    tick();
    chk_idle("t6_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Upstream feeder for the overlapping sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on ser_out, which drives the detector's data_in. A one-entry holding register lets back-to-back words stream with no idle bit between them. Frame and valid markers let the bench and downstream logic align detector pulses to word boundaries.

Parameters:
WIDTH, 8, bits per parallel word (>=2)
MSB_FIRST, 1, 1: bit WIDTH-1 shifted first; 0: bit 0 first
IDLE_BIT, 0, value driven on ser_out when no word is shifting

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
clear  input  1  synchronous abort: drops shifting word and held word
load_data  input  WIDTH  parallel word to serialize
load_valid  input  1  load_data valid
load_ready  output  1  serializer can accept a word this cycle
ser_out  output  1  serial bit stream, to detector data_in
bit_valid  output  1  ser_out carries a data bit
frame_start  output  1  high during the first bit of each word
busy  output  1  word currently shifting (state SHIFT)

Behaviour:
- Reset (reset=0, async): state IDLE, hold empty, cnt=0, ser_out=IDLE_BIT, bit_valid=0, frame_start=0, busy=0, load_ready=1.
- Storage: shift register sh[WIDTH], counter cnt[$clog2(WIDTH)], hold register hold_data, flag hold_full.
- load_ready = ~hold_full, decoded directly from the hold_full register. It never depends combinationally on load_valid.
- Accept occurs at an edge where load_valid && load_ready.
- All outputs are registered and change only on the clock edge, or immediately on asynchronous reset.
- IDLE:
  - ser_out=IDLE_BIT, bit_valid=0.
  - Accept -> load sh from load_data, cnt=0, go to SHIFT.
  - The first bit appears on ser_out after the accept edge, with bit_valid=1 and frame_start=1 (latency 1 cycle).
- SHIFT:
  - Each cycle, ser_out = next bit in MSB_FIRST order and bit_valid=1. frame_start=1 only when cnt==0. cnt increments.
  - Accept while shifting -> load_data goes to hold_data and hold_full is set.
- Last bit (cnt==WIDTH-1):
  - If hold_full: sh<=hold_data, clear hold_full, cnt=0, stay in SHIFT. The next word is gapless.
  - Else if an accept occurs on this same edge (hold empty): load sh directly from load_data, gapless.
  - Else: go to IDLE. ser_out returns to IDLE_BIT and bit_valid=0 on the next cycle.
- Simultaneous events:
  - hold_full reload and a new accept on the same edge cannot happen, because load_ready=0 while the hold is full.
  - When the hold empties, load_ready rises on the following cycle.
- clear=1 (synchronous) has priority over accept and shifting.
  - Next state: IDLE, hold empty, cnt=0, all outputs at their idle values.
  - A word presented during clear is not accepted, even though load_ready is high in that cycle.
- Reset asserted mid-word: the in-flight bits are lost. After release the block is in IDLE, with no partial word and no stale hold_data emitted.
- load_data is ignored whenever no accept occurs.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: reset release, then accept 8'hD6 -> ser_out = 1,1,0,1,0,1,1,0 on the 8 cycles after the accept edge. bit_valid=1 for exactly 8 cycles. frame_start=1 only on the first. Then ser_out=0, busy=0.
2. Back-to-back: accept 8'hD6, then 8'h0D at the next cycle (goes to hold) -> 16 contiguous valid bits 11010110 00001101. frame_start on bits 1 and 9. load_ready=0 from the hold accept until the reload edge.
3. Accept at the last bit with hold empty: present 8'hFF exactly when cnt==7 -> no gap cycle, frame_start on the next cycle, 8 ones follow.
4. MSB_FIRST=0, word 8'h0B -> ser_out = 1,1,0,1,0,0,0,0.
5. clear asserted at bit 3 of 8'hD6 with 8'hAA held -> next cycle IDLE, bit_valid=0, load_ready=1. 8'hAA is never emitted.
6. reset pulled low mid-word -> outputs go to idle values immediately (async). After release, the first accepted word starts cleanly with frame_start=1.
